// File: rtl/dmem_resp.sv
// Single-port data memory responder: byte-lane writes, 1-cycle registered reads, sticky range error.
// Optional access counters are built only when DMEM_STATS_EN is defined.
module dmem_resp #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dce,
  input  logic [31:0] daddr,
  input  logic [3:0]  we,
  input  logic [31:0] din,
  output logic [31:0] dm,
  output logic        err,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  logic [31:0]       mem [0:(1 << ADDR_W) - 1];
  logic [ADDR_W-1:0] word_idx;
  logic              in_range;
  logic              rd_req;
  logic              wr_req;
  logic              unused_byte_offset;

  assign word_idx           = daddr[ADDR_W+1:2];
  assign in_range           = (daddr[31:ADDR_W+2] == '0);
  assign rd_req             = dce && (we == 4'b0000);
  assign wr_req             = dce && (we != 4'b0000);
  assign unused_byte_offset = ^daddr[1:0];

  // Storage has no reset so it maps onto block RAM; contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && wr_req && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem[word_idx][8*i +: 8] <= din[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dm <= 32'h0;
    end else if (rd_req) begin
      dm <= in_range ? mem[word_idx] : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (dce && !in_range) begin
      err <= 1'b1;
    end
  end

`ifdef DMEM_STATS_EN
  // Out-of-range accesses still count; counters wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt <= 32'h0;
      wr_cnt <= 32'h0;
    end else begin
      if (rd_req) rd_cnt <= rd_cnt + 32'd1;
      if (wr_req) wr_cnt <= wr_cnt + 32'd1;
    end
  end
`else
  assign rd_cnt = 32'h0;
  assign wr_cnt = 32'h0;
`endif

endmodule
